// File: rtl/icache_pkg.sv
// Shared types, default geometry and address-field helpers for the direct-mapped
// instruction cache.
package icache_pkg;

    localparam int INDEX_BITS_DEF      = 6;
    localparam int LINE_WORDS_LOG2_DEF = 2;
    localparam int TAG_BITS_DEF        = 32 - INDEX_BITS_DEF - LINE_WORDS_LOG2_DEF - 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_REFILL = 1'b1
    } icache_state_e;

    // Helpers return right-justified 32-bit fields so they work for any geometry.
    function automatic logic [31:0] addr_tag(input logic [31:0] addr,
                                             input int index_bits,
                                             input int words_log2);
        return addr >> (index_bits + words_log2 + 2);
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr,
                                               input int index_bits,
                                               input int words_log2);
        return (addr >> (words_log2 + 2)) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_offset(input logic [31:0] addr,
                                                input int words_log2);
        return (addr >> 2) & ((32'd1 << words_log2) - 32'd1);
    endfunction

    function automatic logic [31:0] line_base(input logic [31:0] addr,
                                              input int words_log2);
        return addr & ~((32'd1 << (words_log2 + 2)) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_data_array.sv
// Instruction cache data storage: one word per (line, offset), combinational read,
// single synchronous write port used by the refill engine.
module icache_data_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS      = INDEX_BITS_DEF,
    parameter int LINE_WORDS_LOG2 = LINE_WORDS_LOG2_DEF
) (
    input  logic                       clk,
    input  logic [INDEX_BITS-1:0]      rd_index,
    input  logic [LINE_WORDS_LOG2-1:0] rd_offset,
    output logic [31:0]                rd_data,
    input  logic                       we,
    input  logic [INDEX_BITS-1:0]      wr_index,
    input  logic [LINE_WORDS_LOG2-1:0] wr_offset,
    input  logic [31:0]                wr_data
);

    localparam int DEPTH = 1 << (INDEX_BITS + LINE_WORDS_LOG2);

    logic [31:0] words_r [DEPTH];

    assign rd_data = words_r[{rd_index, rd_offset}];

    // Refill write port; contents are qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            words_r[{wr_index, wr_offset}] <= wr_data;
        end
    end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: combinational hit path to fetch, line refill
// from memory one word at a time, and whole-cache invalidate for fence.i.
module inst_cache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS      = INDEX_BITS_DEF,
    parameter int LINE_WORDS_LOG2 = LINE_WORDS_LOG2_DEF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic [31:0] fetch_addr,
    output logic        inst_available,
    output logic [31:0] inst,
    input  logic        flush_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic [31:0] mem_data
);

    localparam int TAG_BITS = 32 - INDEX_BITS - LINE_WORDS_LOG2 - 2;
    localparam int LINES    = 1 << INDEX_BITS;
    localparam logic [LINE_WORDS_LOG2-1:0] CNT_ONE  = LINE_WORDS_LOG2'(1);
    localparam logic [LINE_WORDS_LOG2-1:0] CNT_LAST = {LINE_WORDS_LOG2{1'b1}};

    icache_state_e               state_r;
    logic [LINES-1:0]            valid_r;
    logic [TAG_BITS-1:0]         tag_r [LINES];
    logic [INDEX_BITS-1:0]       line_idx_r;
    logic [LINE_WORDS_LOG2-1:0]  cnt_r;
    logic                        poison_r;

    logic [31:0]                 f_tag_w_s;
    logic [31:0]                 f_idx_w_s;
    logic [31:0]                 f_off_w_s;
    logic [31:0]                 f_base_s;
    logic [TAG_BITS-1:0]         f_tag_s;
    logic [INDEX_BITS-1:0]       f_idx_s;
    logic [LINE_WORDS_LOG2-1:0]  f_off_s;
    logic                        hit_s;
    logic                        wr_en_s;
    logic [31:0]                 rd_data_s;
    logic                        unused_field_bits_s;

    // Split the fetch PC into tag / index / word offset.
    always_comb begin
        f_tag_w_s = addr_tag(fetch_addr, INDEX_BITS, LINE_WORDS_LOG2);
        f_idx_w_s = addr_index(fetch_addr, INDEX_BITS, LINE_WORDS_LOG2);
        f_off_w_s = addr_offset(fetch_addr, LINE_WORDS_LOG2);
        f_base_s  = line_base(fetch_addr, LINE_WORDS_LOG2);
    end

    assign f_tag_s = f_tag_w_s[TAG_BITS-1:0];
    assign f_idx_s = f_idx_w_s[INDEX_BITS-1:0];
    assign f_off_s = f_off_w_s[LINE_WORDS_LOG2-1:0];
    assign unused_field_bits_s = ^{f_tag_w_s[31:TAG_BITS],
                                   f_idx_w_s[31:INDEX_BITS],
                                   f_off_w_s[31:LINE_WORDS_LOG2]};

    // The line being refilled is held invalid, so it can never hit mid-refill.
    always_comb begin
        hit_s = valid_r[f_idx_s] && (tag_r[f_idx_s] == f_tag_s);
        if (hit_s) begin
            inst_available = 1'b1;
            inst           = rd_data_s;
        end else begin
            inst_available = 1'b0;
            inst           = 32'd0;
        end
    end

    assign wr_en_s = rdy_in && (state_r == ST_REFILL) && mem_ready;

    icache_data_array #(
        .INDEX_BITS      (INDEX_BITS),
        .LINE_WORDS_LOG2 (LINE_WORDS_LOG2)
    ) u_data (
        .clk       (clk_in),
        .rd_index  (f_idx_s),
        .rd_offset (f_off_s),
        .rd_data   (rd_data_s),
        .we        (wr_en_s),
        .wr_index  (line_idx_r),
        .wr_offset (cnt_r),
        .wr_data   (mem_data)
    );

    // Refill FSM with tag/valid bookkeeping; rdy_in low freezes everything.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_r    <= ST_IDLE;
            valid_r    <= {LINES{1'b0}};
            line_idx_r <= {INDEX_BITS{1'b0}};
            cnt_r      <= {LINE_WORDS_LOG2{1'b0}};
            poison_r   <= 1'b0;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            for (int i = 0; i < LINES; i++) begin
                tag_r[i] <= {TAG_BITS{1'b0}};
            end
        end else if (rdy_in) begin
            if (flush_in) begin
                valid_r <= {LINES{1'b0}};
            end
            case (state_r)
                ST_IDLE: begin
                    if (!hit_s && !flush_in) begin
                        state_r          <= ST_REFILL;
                        line_idx_r       <= f_idx_s;
                        valid_r[f_idx_s] <= 1'b0;
                        tag_r[f_idx_s]   <= f_tag_s;
                        cnt_r            <= {LINE_WORDS_LOG2{1'b0}};
                        poison_r         <= 1'b0;
                        mem_req          <= 1'b1;
                        mem_addr         <= f_base_s;
                    end
                end
                ST_REFILL: begin
                    // The outstanding request cannot be cancelled; a flush only
                    // prevents the line from being validated.
                    if (flush_in) begin
                        poison_r <= 1'b1;
                    end
                    if (mem_ready) begin
                        cnt_r <= cnt_r + CNT_ONE;
                        if (cnt_r == CNT_LAST) begin
                            if (!poison_r && !flush_in) begin
                                valid_r[line_idx_r] <= 1'b1;
                            end
                            state_r  <= ST_IDLE;
                            poison_r <= 1'b0;
                            mem_req  <= 1'b0;
                        end else begin
                            mem_addr <= mem_addr + 32'd4;
                        end
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    poison_r <= 1'b0;
                    mem_req  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache with a hand-driven memory responder.
module tb_inst_cache;

    logic        clk_in;
    logic        rst_in;
    logic        rdy_in;
    logic [31:0] fetch_addr;
    logic        inst_available;
    logic [31:0] inst;
    logic        flush_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic [31:0] mem_data;

    int checks;
    int errors;

    inst_cache dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .fetch_addr     (fetch_addr),
        .inst_available (inst_available),
        .inst           (inst),
        .flush_in       (flush_in),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic fetch_expect(input logic [31:0] addr, input logic avail, input logic [31:0] word);
        fetch_addr = addr;
        #1;
        check_val("inst_available", {31'd0, inst_available}, {31'd0, avail});
        check_val("inst", inst, word);
    endtask

    // Wait lat-1 idle cycles, then return one word while checking the request.
    task automatic serve_word(input logic [31:0] exp_addr, input logic [31:0] data, input int lat);
        for (int i = 0; i < lat - 1; i++) tick();
        check_val("mem_req_during_refill", {31'd0, mem_req}, 32'd1);
        check_val("mem_addr", mem_addr, exp_addr);
        mem_ready = 1'b1;
        mem_data  = data;
        tick();
        mem_ready = 1'b0;
        mem_data  = 32'd0;
    endtask

    task automatic serve_line(input logic [31:0] base, input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3, input int lat);
        serve_word(base,         d0, lat);
        serve_word(base + 32'd4, d1, lat);
        serve_word(base + 32'd8, d2, lat);
        serve_word(base + 32'hC, d3, lat);
        check_val("mem_req_after_line", {31'd0, mem_req}, 32'd0);
    endtask

    task automatic expect_refill_start(input logic [31:0] base);
        tick();
        check_val("mem_req_start", {31'd0, mem_req}, 32'd1);
        check_val("mem_addr_start", mem_addr, base);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        fetch_addr = 32'd0;
        flush_in   = 1'b0;
        mem_ready  = 1'b0;
        mem_data   = 32'd0;

        // Reset state
        #1;
        check_val("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("rst_mem_addr", mem_addr, 32'd0);
        fetch_expect(32'h0, 1'b0, 32'd0);
        tick();
        tick();
        rst_in = 1'b0;

        // Cold miss on 0x0, 2-cycle memory latency
        fetch_expect(32'h0, 1'b0, 32'd0);
        expect_refill_start(32'h0);
        fetch_expect(32'h0, 1'b0, 32'd0);
        serve_line(32'h0, 32'h00000013, 32'h11, 32'h22, 32'h33, 2);
        fetch_expect(32'h0, 1'b1, 32'h00000013);
        fetch_expect(32'h8, 1'b1, 32'h22);
        fetch_expect(32'hB, 1'b1, 32'h33 - 32'h11);
        fetch_expect(32'hC, 1'b1, 32'h33);
        tick();
        check_val("hit_no_req", {31'd0, mem_req}, 32'd0);

        // Conflict eviction: 0x400 shares index 0 with 0x0
        fetch_expect(32'h400, 1'b0, 32'd0);
        expect_refill_start(32'h400);
        serve_line(32'h400, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 2);
        fetch_expect(32'h400, 1'b1, 32'hA0);
        fetch_expect(32'h404, 1'b1, 32'hA1);
        fetch_expect(32'h0, 1'b0, 32'd0);
        expect_refill_start(32'h0);
        serve_line(32'h0, 32'h00000013, 32'h11, 32'h22, 32'h33, 2);
        fetch_expect(32'h4, 1'b1, 32'h11);

        // Flush after the 2nd response: two more consumed, line stays invalid
        fetch_expect(32'h40, 1'b0, 32'd0);
        expect_refill_start(32'h40);
        serve_word(32'h40, 32'h40, 2);
        serve_word(32'h44, 32'h41, 2);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        serve_word(32'h48, 32'h42, 2);
        serve_word(32'h4C, 32'h43, 2);
        check_val("flush_req_drop", {31'd0, mem_req}, 32'd0);
        fetch_expect(32'h0, 1'b0, 32'd0);
        fetch_expect(32'h40, 1'b0, 32'd0);
        expect_refill_start(32'h40);
        serve_line(32'h40, 32'h50, 32'h51, 32'h52, 32'h53, 2);
        fetch_expect(32'h4C, 1'b1, 32'h53);

        // fetch_addr moves from 0x10 to 0x20 mid-refill
        fetch_expect(32'h10, 1'b0, 32'd0);
        expect_refill_start(32'h10);
        serve_word(32'h10, 32'h60, 1);
        fetch_addr = 32'h20;
        serve_word(32'h14, 32'h61, 1);
        serve_word(32'h18, 32'h62, 1);
        serve_word(32'h1C, 32'h63, 1);
        check_val("move_req_drop", {31'd0, mem_req}, 32'd0);
        fetch_expect(32'h20, 1'b0, 32'd0);
        expect_refill_start(32'h20);
        serve_line(32'h20, 32'h70, 32'h71, 32'h72, 32'h73, 1);
        fetch_expect(32'h24, 1'b1, 32'h71);
        fetch_expect(32'h18, 1'b1, 32'h62);

        // rdy_in low for 3 cycles mid-refill, with a stray mem_ready ignored
        fetch_expect(32'h30, 1'b0, 32'd0);
        expect_refill_start(32'h30);
        serve_word(32'h30, 32'h80, 2);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin
                mem_ready = 1'b1;
                mem_data  = 32'hDEADBEEF;
            end
            tick();
            mem_ready = 1'b0;
            mem_data  = 32'd0;
            check_val("stall_mem_req", {31'd0, mem_req}, 32'd1);
            check_val("stall_mem_addr", mem_addr, 32'h34);
        end
        rdy_in = 1'b1;
        serve_word(32'h34, 32'h81, 2);
        serve_word(32'h38, 32'h82, 2);
        serve_word(32'h3C, 32'h83, 2);
        check_val("stall_req_drop", {31'd0, mem_req}, 32'd0);
        fetch_expect(32'h34, 1'b1, 32'h81);
        fetch_expect(32'h3C, 1'b1, 32'h83);

        // Async reset between edges in the middle of a refill
        fetch_expect(32'h50, 1'b0, 32'd0);
        expect_refill_start(32'h50);
        serve_word(32'h50, 32'h90, 2);
        fetch_addr = 32'h30;
        #2;
        rst_in = 1'b1;
        #1;
        check_val("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
        check_val("async_rst_mem_addr", mem_addr, 32'd0);
        check_val("async_rst_avail", {31'd0, inst_available}, 32'd0);
        check_val("async_rst_inst", inst, 32'd0);
        tick();
        rst_in = 1'b0;
        fetch_expect(32'h0, 1'b0, 32'd0);
        expect_refill_start(32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
